// File: rtl/sync_sample_checker.sv
// sync_sample_checker
// Receiving end of the counter-synchronizer experiment. The external sample
// clock's rising edge is found in the clk domain. Each new sample is checked
// against the expected binary or Gray progression. Sample and violation
// counts, the last offending pair and a sticky error flag can be read back
// through a registered byte-wide port.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for the first (reference) sample after reset/clear
//   LEARN | binary mode: the next sample sets the expected step
//   RUN   | every sample is checked against the previous one

module sync_sample_checker #(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_clk,
    input  logic [W-1:0] sample_in,
    input  logic         mode,
    input  logic         clear,
    input  logic [2:0]   sel,
    output logic [7:0]   dout,
    output logic         err_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEARN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_s1, r_s2, r_s3;
    logic               w_new;
    logic [W-1:0]       r_prev;
    logic [W-1:0]       r_step;
    logic [W-1:0]       w_delta;
    logic [W-1:0]       w_diff;
    logic [7:0]         w_pop;
    logic               w_bad;
    logic               w_load_step;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_err_flag;
    logic [7:0]         r_last_bad;
    logic [7:0]         r_dout;

    // Widen or truncate a W-bit value to exactly 4 bits for the readout fields.
    function automatic logic [3:0] to_nibble(input logic [W-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < W) n[i] = v[i];
        end
        return n;
    endfunction

    // Pick byte idx out of a counter. Bits at or above CNT_W read as zero.
    function automatic logic [7:0] cnt_byte(input logic [CNT_W-1:0] c, input int idx);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            if (idx * 8 + i < CNT_W) b[i] = c[idx*8 + i];
        end
        return b;
    endfunction

    assign w_new   = r_s2 & ~r_s3;
    assign w_delta = sample_in - r_prev;
    assign w_diff  = sample_in ^ r_prev;

    // Bring the sample clock into clk: two flops for metastability, one for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sample_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Count how many bits changed between consecutive samples, for the Gray check.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < W; i++) begin
            w_pop = w_pop + {7'b0, w_diff[i]};
        end
    end

    // FSM next state and the per-sample check. Nothing moves without a new sample.
    always_comb begin
        w_state_nxt = r_state;
        w_bad       = 1'b0;
        w_load_step = 1'b0;
        if (w_new) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = mode ? ST_RUN : ST_LEARN;
                ST_LEARN: begin
                    w_load_step = 1'b1;
                    w_state_nxt = ST_RUN;
                end
                ST_RUN:   w_bad = mode ? (w_pop > 8'd1) : (w_delta != r_step);
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register. A clear overrides any sample arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_state <= ST_IDLE;
        else if (clear)  r_state <= ST_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Reference, step, saturating counters and error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_step       <= '0;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_err_flag   <= 1'b0;
            r_last_bad   <= '0;
        end else if (clear) begin
            r_prev       <= '0;
            r_step       <= '0;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_err_flag   <= 1'b0;
            r_last_bad   <= '0;
        end else if (w_new) begin
            r_prev <= sample_in;
            if (w_load_step) r_step <= w_delta;
            if (r_sample_cnt != '1) r_sample_cnt <= r_sample_cnt + 1'b1;
            if (w_bad) begin
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
                r_err_flag <= 1'b1;
                r_last_bad <= {to_nibble(r_prev), to_nibble(sample_in)};
            end
        end
    end

    // Registered readout mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else begin
            case (sel)
                3'd0:    r_dout <= cnt_byte(r_sample_cnt, 0);
                3'd1:    r_dout <= cnt_byte(r_sample_cnt, 1);
                3'd2:    r_dout <= cnt_byte(r_err_cnt, 0);
                3'd3:    r_dout <= cnt_byte(r_err_cnt, 1);
                3'd4:    r_dout <= r_last_bad;
                3'd5:    r_dout <= {3'b0, mode, to_nibble(r_step)};
                3'd6:    r_dout <= {5'b0, r_err_flag, r_state};
                default: r_dout <= 8'h00;
            endcase
        end
    end

    assign dout     = r_dout;
    assign err_flag = r_err_flag;

endmodule

// File: tb/tb_sync_sample_checker.sv
// Directed bench for sync_sample_checker. A second instance with a 9-bit
// counter width shares the stimulus so that saturation is reachable in a
// short run.

module tb_sync_sample_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_clk = 1'b0;
    logic [3:0] sample_in = 4'h0;
    logic       mode = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] sel = 3'd6;
    logic [7:0] dout_a, dout_b;
    logic       err_a, err_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_sample_checker #(.W(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .sample_in(sample_in),
        .mode(mode), .clear(clear), .sel(sel), .dout(dout_a), .err_flag(err_a)
    );

    sync_sample_checker #(.W(4), .CNT_W(9)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .sample_in(sample_in),
        .mode(mode), .clear(clear), .sel(sel), .dout(dout_b), .err_flag(err_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] v);
        sample_in  = v;
        sample_clk = 1'b1;
        tick(6);
        sample_clk = 1'b0;
        tick(4);
    endtask

    task automatic do_clear(input logic m);
        clear = 1'b1;
        mode  = m;
        tick(2);
        clear = 1'b0;
        tick(1);
    endtask

    task automatic rd(input string tag, input logic [2:0] s, input bit use_b, input logic [7:0] exp);
        logic [7:0] obs;
        sel = s;
        tick(2);
        obs = use_b ? dout_b : dout_a;
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk_flag(input string tag, input logic exp);
        n_cmp++;
        assert (err_a === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, err_a, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        rd("rst_dout_sel6", 3'd6, 0, 8'h00);
        chk_flag("rst_err_flag", 1'b0);
        rst_n = 1'b1;
        tick(10);
        for (int s = 0; s < 8; s++) begin
            rd($sformatf("idle_sel%0d", s), 3'(s), 0, 8'h00);
        end

        // Binary progression with wrap 15->3
        mode = 1'b0;
        send(4'd3); send(4'd7); send(4'd11); send(4'd15); send(4'd3); send(4'd7);
        rd("bin_cnt",   3'd0, 0, 8'h06);
        rd("bin_err",   3'd2, 0, 8'h00);
        rd("bin_step",  3'd5, 0, 8'h04);
        rd("bin_state", 3'd6, 0, 8'h02);
        chk_flag("bin_flag", 1'b0);

        // Binary with one bad delta
        do_clear(1'b0);
        send(4'd0); send(4'd5); send(4'd10); send(4'd14); send(4'd3);
        rd("bad_cnt",   3'd0, 0, 8'h05);
        rd("bad_err",   3'd2, 0, 8'h01);
        rd("bad_last",  3'd4, 0, 8'hAE);
        rd("bad_state", 3'd6, 0, 8'h06);
        chk_flag("bad_flag", 1'b1);

        // Gray progression, 6->5 changes two bits
        do_clear(1'b1);
        send(4'd0); send(4'd1); send(4'd3); send(4'd2); send(4'd6); send(4'd5);
        rd("gray_cnt",   3'd0, 0, 8'h06);
        rd("gray_err",   3'd2, 0, 8'h01);
        rd("gray_last",  3'd4, 0, 8'h65);
        rd("gray_mode",  3'd5, 0, 8'h10);
        rd("gray_state", 3'd6, 0, 8'h06);

        // Clear coincident with new_sample: the sample is dropped
        sample_in  = 4'd9;
        sample_clk = 1'b1;
        tick(1);
        clear = 1'b1;
        mode  = 1'b0;
        tick(3);
        clear = 1'b0;
        tick(2);
        sample_clk = 1'b0;
        tick(4);
        rd("clr_cnt",   3'd0, 0, 8'h00);
        rd("clr_state", 3'd6, 0, 8'h00);
        send(4'd4);
        rd("ref_cnt",   3'd0, 0, 8'h01);
        rd("ref_state", 3'd6, 0, 8'h01);
        rd("ref_err",   3'd2, 0, 8'h00);
        send(4'd6);
        rd("learn_step", 3'd5, 0, 8'h02);

        // Saturation: 520 Gray samples alternating 0/3, 519 of them illegal
        do_clear(1'b1);
        for (int k = 0; k < 520; k++) begin
            send((k % 2 == 0) ? 4'd0 : 4'd3);
        end
        rd("sat_cnt_lo", 3'd0, 1, 8'hFF);
        rd("sat_cnt_hi", 3'd1, 1, 8'h01);
        rd("sat_err_lo", 3'd2, 1, 8'hFF);
        rd("sat_err_hi", 3'd3, 1, 8'h01);
        rd("wide_cnt_lo", 3'd0, 0, 8'h08);
        rd("wide_cnt_hi", 3'd1, 0, 8'h02);
        rd("wide_err_lo", 3'd2, 0, 8'h07);
        rd("wide_err_hi", 3'd3, 0, 8'h02);
        rd("sel7_zero",   3'd7, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
